// File: rtl/link_pkg.sv
// Shared types and default parameters for the CPU <-> Arduino byte link.
package link_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic [1:0] {
      T_IDLE,
      T_SETUP,
      T_REQ,
      T_REL
   } tx_state_t;

   typedef enum logic {
      R_IDLE,
      R_ACK
   } rx_state_t;

   localparam int unsigned SYNC_STAGES_DEF    = 2;
   localparam int unsigned TX_DEPTH_DEF       = 4;
   localparam int unsigned BYTES_PER_WORD_DEF = 2;
   localparam int unsigned TIMEOUT_DEF        = 1023;

   // True when more than one of three push strobes is asserted.
   function automatic logic multi_hot3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchronizer for asynchronous Arduino handshake inputs.
module sync_ff #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ard_link.sv
// Byte link between CPU control and the Arduino host: TX byte FIFO with 4-phase
// req/ack sender, and an RX word buffer filled by a 4-phase receiver.
module ard_link
   import link_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
   parameter int unsigned TX_DEPTH       = TX_DEPTH_DEF,
   parameter int unsigned BYTES_PER_WORD = BYTES_PER_WORD_DEF,
   parameter int unsigned TIMEOUT        = TIMEOUT_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       bus_pc,
   input  logic       bus_mar,
   input  logic       bus_mdr,
   input  logic [7:0] pc_byte,
   input  logic [7:0] mar_byte,
   input  logic [7:0] mdr_byte,
   input  logic       mdr_shift_in,
   input  logic       instr_shift_in,
   output logic [7:0] rx_byte,
   output logic       ard_receive_ready,
   output logic       ard_data_ready,
   input  logic       ard_rdy,
   output logic [7:0] ard_d_out,
   output logic       ard_tx_req,
   input  logic       ard_tx_ack,
   input  logic [7:0] ard_d_in,
   input  logic       ard_rx_req,
   output logic       ard_rx_ack,
   output logic       link_err
);

   localparam int unsigned AW = $clog2(TX_DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned IW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
   localparam int unsigned WW = $clog2(BYTES_PER_WORD + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   logic rdy_s, ack_s, req_s;

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_rdy (.clk(clk), .rst_n(rst_n), .d(ard_rdy),    .q(rdy_s));
   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ack (.clk(clk), .rst_n(rst_n), .d(ard_tx_ack), .q(ack_s));
   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_req (.clk(clk), .rst_n(rst_n), .d(ard_rx_req), .q(req_s));

   tx_state_t       tx_state_q, tx_state_d;
   rx_state_t       rx_state_q, rx_state_d;
   byte_t           tx_mem_q [TX_DEPTH];
   byte_t           tx_mem_d [TX_DEPTH];
   logic [PW-1:0]   tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [TW-1:0]   tx_tmr_q, tx_tmr_d, rx_tmr_q, rx_tmr_d;
   byte_t           d_out_q, d_out_d;
   logic            tx_req_q, tx_req_d;
   logic            rr_q, rr_d;
   byte_t           rx_buf_q [BYTES_PER_WORD];
   byte_t           rx_buf_d [BYTES_PER_WORD];
   logic [WW-1:0]   rx_wr_q, rx_wr_d;
   logic [IW-1:0]   rx_rd_q, rx_rd_d;
   logic            dr_q, dr_d;
   logic            rx_ack_q, rx_ack_d;
   logic            err_q, err_d;

   logic            push_any_c, push_multi_c, push_ok_c;
   byte_t           push_byte_c;
   logic            fifo_empty_c, fifo_full_c;
   logic            tx_to_c, tx_pop_c;
   logic            rx_to_c, rx_cap_c, rx_full_c, rx_pop_c;

   // Push arbitration: pc wins over mar, mar over mdr.
   always_comb begin
      push_any_c   = bus_pc | bus_mar | bus_mdr;
      push_multi_c = multi_hot3(bus_pc, bus_mar, bus_mdr);
      push_byte_c  = bus_pc ? pc_byte : (bus_mar ? mar_byte : mdr_byte);
      fifo_empty_c = (tx_wr_q == tx_rd_q);
      fifo_full_c  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
      push_ok_c    = push_any_c & ~fifo_full_c;
      rx_full_c    = (rx_wr_q == WW'(BYTES_PER_WORD));
   end

   // State register and all datapath flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q <= T_IDLE;
         rx_state_q <= R_IDLE;
         tx_mem_q   <= '{default: '0};
         tx_wr_q    <= '0;
         tx_rd_q    <= '0;
         tx_tmr_q   <= '0;
         rx_tmr_q   <= '0;
         d_out_q    <= '0;
         tx_req_q   <= 1'b0;
         rr_q       <= 1'b0;
         rx_buf_q   <= '{default: '0};
         rx_wr_q    <= '0;
         rx_rd_q    <= '0;
         dr_q       <= 1'b0;
         rx_ack_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         rx_state_q <= rx_state_d;
         tx_mem_q   <= tx_mem_d;
         tx_wr_q    <= tx_wr_d;
         tx_rd_q    <= tx_rd_d;
         tx_tmr_q   <= tx_tmr_d;
         rx_tmr_q   <= rx_tmr_d;
         d_out_q    <= d_out_d;
         tx_req_q   <= tx_req_d;
         rr_q       <= rr_d;
         rx_buf_q   <= rx_buf_d;
         rx_wr_q    <= rx_wr_d;
         rx_rd_q    <= rx_rd_d;
         dr_q       <= dr_d;
         rx_ack_q   <= rx_ack_d;
         err_q      <= err_d;
      end
   end

   // TX next state; a stalled handshake edge abandons the transfer.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_to_c    = 1'b0;
      case (tx_state_q)
         T_IDLE:  if (!fifo_empty_c && rdy_s) tx_state_d = T_SETUP;
         T_SETUP: tx_state_d = T_REQ;
         T_REQ: begin
            if (ack_s) begin
               tx_state_d = T_REL;
            end else if (tx_tmr_q == TW'(TIMEOUT - 1)) begin
               tx_to_c    = 1'b1;
               tx_state_d = T_IDLE;
            end
         end
         T_REL: begin
            if (!ack_s) begin
               tx_state_d = T_IDLE;
            end else if (tx_tmr_q == TW'(TIMEOUT - 1)) begin
               tx_to_c    = 1'b1;
               tx_state_d = T_IDLE;
            end
         end
         default: tx_state_d = T_IDLE;
      endcase
   end

   // TX outputs, FIFO pointers and handshake timer.
   always_comb begin
      tx_mem_d = tx_mem_q;
      d_out_d  = d_out_q;
      tx_pop_c = (tx_state_q == T_REQ) && (ack_s || tx_to_c);
      if (push_ok_c) tx_mem_d[tx_wr_q[AW-1:0]] = push_byte_c;
      if (tx_state_q == T_IDLE && tx_state_d == T_SETUP) d_out_d = tx_mem_q[tx_rd_q[AW-1:0]];
      tx_wr_d  = tx_wr_q + PW'(push_ok_c);
      tx_rd_d  = tx_rd_q + PW'(tx_pop_c);
      tx_req_d = (tx_state_d == T_REQ);
      rr_d     = rdy_s & fifo_empty_c & (tx_state_q == T_IDLE) & ~push_any_c;
      if (tx_state_d != tx_state_q) begin
         tx_tmr_d = '0;
      end else if (tx_state_q == T_REQ || tx_state_q == T_REL) begin
         tx_tmr_d = tx_tmr_q + TW'(1);
      end else begin
         tx_tmr_d = '0;
      end
   end

   // RX next state; a full word back-pressures the Arduino by withholding ack.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cap_c   = 1'b0;
      rx_to_c    = 1'b0;
      case (rx_state_q)
         R_IDLE: begin
            if (req_s && !rx_full_c) begin
               rx_cap_c   = 1'b1;
               rx_state_d = R_ACK;
            end
         end
         R_ACK: begin
            if (!req_s) begin
               rx_state_d = R_IDLE;
            end else if (rx_tmr_q == TW'(TIMEOUT - 1)) begin
               rx_to_c    = 1'b1;
               rx_state_d = R_IDLE;
            end
         end
         default: rx_state_d = R_IDLE;
      endcase
   end

   // RX outputs, word buffer, consumer pops and sticky error.
   always_comb begin
      rx_buf_d = rx_buf_q;
      rx_wr_d  = rx_wr_q;
      rx_rd_d  = rx_rd_q;
      dr_d     = dr_q;
      rx_ack_d = (rx_state_d == R_ACK);
      rx_pop_c = (mdr_shift_in | instr_shift_in) & dr_q;
      if (rx_cap_c) begin
         rx_buf_d[rx_wr_q[IW-1:0]] = ard_d_in;
         rx_wr_d = rx_wr_q + WW'(1);
         if (rx_wr_q == WW'(BYTES_PER_WORD - 1)) dr_d = 1'b1;
      end
      if (rx_to_c && !dr_q) rx_wr_d = '0;
      if (rx_pop_c) begin
         if (rx_rd_q == IW'(BYTES_PER_WORD - 1)) begin
            dr_d    = 1'b0;
            rx_wr_d = '0;
            rx_rd_d = '0;
         end else begin
            rx_rd_d = rx_rd_q + IW'(1);
         end
      end
      if (rx_state_d != rx_state_q || rx_state_q != R_ACK) begin
         rx_tmr_d = '0;
      end else begin
         rx_tmr_d = rx_tmr_q + TW'(1);
      end
      err_d = err_q | push_multi_c | (push_any_c & fifo_full_c) | tx_to_c | rx_to_c;
   end

   assign rx_byte           = rx_buf_q[rx_rd_q];
   assign ard_receive_ready = rr_q;
   assign ard_data_ready    = dr_q;
   assign ard_d_out         = d_out_q;
   assign ard_tx_req        = tx_req_q;
   assign ard_rx_ack        = rx_ack_q;
   assign link_err          = err_q;

endmodule
